// File: rtl/inst_encoder.sv
// inst_encoder: turns a mnemonic-level command into a 32-bit MIPS word and queues it with a word address.
// Latency: a word accepted on edge N is at the FIFO head after edge N when the FIFO was empty.
// Backpressure: in_ready = ~full & ~nop_pending, from registers only; out_ready never reaches in_ready.
//
// Optional build macro: ENCODER_DELAY_SLOT_EN. When it is defined, a NOP is queued after every
// jr/beq/bne/j/jal to fill the branch delay slot.
//
// Ports:
//   clk, clrn                  clock and asynchronous active-low reset
//   in_valid/in_ready          command handshake
//   mnem, rs, rt, rd, sa, imm, target   command fields
//   ld, ld_addr                load the word-address counter
//   out_valid/out_ready        FIFO head handshake
//   out_inst, out_addr         head word and its address
//   level                      FIFO occupancy
//   err, err_cnt               illegal-mnemonic pulse and saturating count
//
// FIFO_DEPTH must be a power of two and at least 2, so the pointers can wrap naturally.

// Generic single-clock FIFO with an occupancy count and no read latency.
// Latency: a push on edge N is readable on dout after edge N.
// Backpressure: a push while full or a pop while empty is ignored.
module inst_encoder_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // The storage array has no reset; the count and pointers say what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module inst_encoder #(
  parameter int AW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [4:0]                  mnem,
  input  logic [4:0]                  rs,
  input  logic [4:0]                  rt,
  input  logic [4:0]                  rd,
  input  logic [4:0]                  sa,
  input  logic [15:0]                 imm,
  input  logic [25:0]                 target,
  input  logic                        ld,
  input  logic [AW-1:0]               ld_addr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_inst,
  output logic [AW-1:0]               out_addr,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        err,
  output logic [7:0]                  err_cnt
);
  // Mnemonic codes, in the same order the control unit decodes them.
  localparam logic [4:0] MN_ADD  = 5'd0;
  localparam logic [4:0] MN_SUB  = 5'd1;
  localparam logic [4:0] MN_AND  = 5'd2;
  localparam logic [4:0] MN_OR   = 5'd3;
  localparam logic [4:0] MN_XOR  = 5'd4;
  localparam logic [4:0] MN_SLL  = 5'd5;
  localparam logic [4:0] MN_SRL  = 5'd6;
  localparam logic [4:0] MN_SRA  = 5'd7;
  localparam logic [4:0] MN_JR   = 5'd8;
  localparam logic [4:0] MN_SLLV = 5'd9;
  localparam logic [4:0] MN_SRLV = 5'd10;
  localparam logic [4:0] MN_SRAV = 5'd11;
  localparam logic [4:0] MN_ADDI = 5'd12;
  localparam logic [4:0] MN_ANDI = 5'd13;
  localparam logic [4:0] MN_ORI  = 5'd14;
  localparam logic [4:0] MN_XORI = 5'd15;
  localparam logic [4:0] MN_LW   = 5'd16;
  localparam logic [4:0] MN_SW   = 5'd17;
  localparam logic [4:0] MN_BEQ  = 5'd18;
  localparam logic [4:0] MN_BNE  = 5'd19;
  localparam logic [4:0] MN_LUI  = 5'd20;
  localparam logic [4:0] MN_J    = 5'd21;
  localparam logic [4:0] MN_JAL  = 5'd22;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [31:0] r_word(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                         input logic [4:0] f_rd, input logic [4:0] f_sa,
                                         input logic [5:0] func);
    return {6'b000000, f_rs, f_rt, f_rd, f_sa, func};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] f_rs,
                                         input logic [4:0] f_rt, input logic [15:0] f_imm);
    return {op, f_rs, f_rt, f_imm};
  endfunction

  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          accept;
  logic          cmd_push;
  logic          nop_push;
  logic          push;
  logic          pending;
  logic          full;
  logic          empty;
  logic [AW-1:0] addr_cnt;
  logic [AW-1:0] push_addr;
  logic [31:0]   push_word;
  logic [31:0]   head_inst;
  logic [AW-1:0] head_addr;
  logic [LW-1:0] fifo_count;

  // Field forcing: plain R-type ALU ops zero sa, immediate shifts zero rs,
  // jr keeps only rs, and lui zeroes rs.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (mnem)
      MN_ADD:  enc_word = r_word(rs, rt, rd, 5'd0, 6'b100000);
      MN_SUB:  enc_word = r_word(rs, rt, rd, 5'd0, 6'b100010);
      MN_AND:  enc_word = r_word(rs, rt, rd, 5'd0, 6'b100100);
      MN_OR:   enc_word = r_word(rs, rt, rd, 5'd0, 6'b100101);
      MN_XOR:  enc_word = r_word(rs, rt, rd, 5'd0, 6'b100110);
      MN_SLL:  enc_word = r_word(5'd0, rt, rd, sa, 6'b000000);
      MN_SRL:  enc_word = r_word(5'd0, rt, rd, sa, 6'b000010);
      MN_SRA:  enc_word = r_word(5'd0, rt, rd, sa, 6'b000011);
      MN_JR:   enc_word = r_word(rs, 5'd0, 5'd0, 5'd0, 6'b001000);
      MN_SLLV: enc_word = r_word(rs, rt, rd, 5'd0, 6'b000100);
      MN_SRLV: enc_word = r_word(rs, rt, rd, 5'd0, 6'b000110);
      MN_SRAV: enc_word = r_word(rs, rt, rd, 5'd0, 6'b000111);
      MN_ADDI: enc_word = i_word(6'b001000, rs, rt, imm);
      MN_ANDI: enc_word = i_word(6'b001100, rs, rt, imm);
      MN_ORI:  enc_word = i_word(6'b001101, rs, rt, imm);
      MN_XORI: enc_word = i_word(6'b001110, rs, rt, imm);
      MN_LW:   enc_word = i_word(6'b100011, rs, rt, imm);
      MN_SW:   enc_word = i_word(6'b101011, rs, rt, imm);
      MN_BEQ:  enc_word = i_word(6'b000100, rs, rt, imm);
      MN_BNE:  enc_word = i_word(6'b000101, rs, rt, imm);
      MN_LUI:  enc_word = i_word(6'b001111, 5'd0, rt, imm);
      MN_J:    enc_word = {6'b000010, target};
      MN_JAL:  enc_word = {6'b000011, target};
      default: enc_legal = 1'b0;
    endcase
  end

  assign in_ready = ~full & ~pending;
  assign accept   = in_valid & in_ready;
  assign cmd_push = accept & enc_legal;

`ifdef ENCODER_DELAY_SLOT_EN
  logic enc_slot;
  logic nop_pending;

  assign enc_slot = (mnem == MN_JR) | (mnem == MN_BEQ) | (mnem == MN_BNE) |
                    (mnem == MN_J)  | (mnem == MN_JAL);
  // A pending NOP holds in_ready low, so it never competes with a command push.
  assign nop_push = nop_pending & ~full;
  assign pending  = nop_pending;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      nop_pending <= 1'b0;
    end else if (cmd_push && enc_slot) begin
      nop_pending <= 1'b1;
    end else if (nop_push) begin
      nop_pending <= 1'b0;
    end
  end
`else
  assign nop_push = 1'b0;
  assign pending  = 1'b0;
`endif

  assign push      = cmd_push | nop_push;
  assign push_word = nop_push ? 32'h0000_0000 : enc_word;
  // ld wins over the running counter, for command words and delay-slot NOPs alike.
  assign push_addr = ld ? ld_addr : addr_cnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      addr_cnt <= '0;
    end else if (push) begin
      addr_cnt <= push_addr + AW'(1);
    end else if (ld) begin
      addr_cnt <= ld_addr;
    end
  end

  // An illegal command completes its handshake but only raises err.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      err <= accept & ~enc_legal;
      if (accept && !enc_legal && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  inst_encoder_fifo #(
    .W     (32 + AW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .din   ({push_addr, push_word}),
    .pop   (out_ready),
    .dout  ({head_addr, head_inst}),
    .empty (empty),
    .full  (full),
    .count (fifo_count)
  );

  // The head is masked while the FIFO is empty, so outputs read zero out of reset.
  assign out_valid = ~empty;
  assign out_inst  = out_valid ? head_inst : 32'h0000_0000;
  assign out_addr  = out_valid ? head_addr : '0;
  assign level     = fifo_count;
endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
  localparam int AW = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          clrn;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    mnem, rs, rt, rd, sa;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          ld;
  logic [AW-1:0] ld_addr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_addr;
  logic [2:0]    level;
  logic          err;
  logic [7:0]    err_cnt;

  inst_encoder #(.AW(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .imm(imm), .target(target),
    .ld(ld), .ld_addr(ld_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .level(level), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  mnem, rs, rt, rd, sa;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp;
    bit          br;
  } vec_t;

  vec_t vt[23];

  function automatic vec_t mk(input int m, input int s, input int t, input int d, input int a,
                              input int im, input int tg, input logic [31:0] e, input bit b);
    vec_t v;
    v.mnem = 5'(m); v.rs = 5'(s); v.rt = 5'(t); v.rd = 5'(d); v.sa = 5'(a);
    v.imm = 16'(im); v.target = 26'(tg); v.exp = e; v.br = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for in_ready, then complete one handshake.
  task automatic send(input logic [4:0] m, input logic [4:0] f_rs, input logic [4:0] f_rt,
                      input logic [4:0] f_rd, input logic [4:0] f_sa, input logic [15:0] f_imm,
                      input logic [25:0] f_tg);
    int budget;
    budget = 20;
    mnem = m; rs = f_rs; rt = f_rt; rd = f_rd; sa = f_sa; imm = f_imm; target = f_tg;
    in_valid = 1'b1;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    chk("send_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    ld = 1'b0;
  endtask

  task automatic send_add(input int d);
    send(5'd0, 5'd0, 5'd0, 5'(d), 5'd0, 16'd0, 26'd0);
  endtask

  // Check the head word and address, then pop it.
  task automatic expect_head(input string name, input logic [31:0] inst, input logic [AW-1:0] addr);
    chk({name, "_vld"}, 32'(out_valid), 32'd1);
    chk({name, "_inst"}, out_inst, inst);
    chk({name, "_addr"}, 32'(out_addr), 32'(addr));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_level"}, 32'(level), 32'd0);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_out_inst"}, out_inst, 32'd0);
    chk({name, "_out_addr"}, 32'(out_addr), 32'd0);
    chk({name, "_err"}, 32'(err), 32'd0);
    chk({name, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] exp_addr;
    int pulses;

    vt[0]  = mk(0,  1, 2, 3, 5,   'hBEEF, 'h2AAAAAA, 32'h00221820, 0);
    vt[1]  = mk(1,  4, 5, 6, 0,   'hBEEF, 'h2AAAAAA, 32'h00853022, 0);
    vt[2]  = mk(2,  8, 9, 10, 0,  'hBEEF, 'h2AAAAAA, 32'h01095024, 0);
    vt[3]  = mk(3,  31, 31, 31, 0,'hBEEF, 'h2AAAAAA, 32'h03FFF825, 0);
    vt[4]  = mk(4,  1, 1, 1, 9,   'hBEEF, 'h2AAAAAA, 32'h00210826, 0);
    vt[5]  = mk(5,  7, 3, 2, 4,   'hBEEF, 'h2AAAAAA, 32'h00031100, 0);
    vt[6]  = mk(6,  3, 2, 5, 31,  'hBEEF, 'h2AAAAAA, 32'h00022FC2, 0);
    vt[7]  = mk(7,  0, 17, 16, 1, 'hBEEF, 'h2AAAAAA, 32'h00118043, 0);
    vt[8]  = mk(8,  31, 1, 2, 3,  'hBEEF, 'h2AAAAAA, 32'h03E00008, 1);
    vt[9]  = mk(9,  4, 5, 6, 7,   'hBEEF, 'h2AAAAAA, 32'h00853004, 0);
    vt[10] = mk(10, 4, 5, 6, 7,   'hBEEF, 'h2AAAAAA, 32'h00853006, 0);
    vt[11] = mk(11, 4, 5, 6, 7,   'hBEEF, 'h2AAAAAA, 32'h00853007, 0);
    vt[12] = mk(12, 1, 2, 31, 31, 'hFFFF, 'h2AAAAAA, 32'h2022FFFF, 0);
    vt[13] = mk(13, 2, 3, 31, 31, 'h00FF, 'h2AAAAAA, 32'h304300FF, 0);
    vt[14] = mk(14, 0, 8, 31, 31, 'h1234, 'h2AAAAAA, 32'h34081234, 0);
    vt[15] = mk(15, 5, 6, 31, 31, 'hAAAA, 'h2AAAAAA, 32'h38A6AAAA, 0);
    vt[16] = mk(16, 29, 4, 31, 31,'h0008, 'h2AAAAAA, 32'h8FA40008, 0);
    vt[17] = mk(17, 29, 31, 31, 31,'hFFFC,'h2AAAAAA, 32'hAFBFFFFC, 0);
    vt[18] = mk(18, 1, 2, 31, 31, 'h0003, 'h2AAAAAA, 32'h10220003, 1);
    vt[19] = mk(19, 3, 0, 31, 31, 'h8000, 'h2AAAAAA, 32'h14608000, 1);
    vt[20] = mk(20, 9, 7, 31, 31, 'hDEAD, 'h2AAAAAA, 32'h3C07DEAD, 0);
    vt[21] = mk(21, 31, 31, 31, 31,'hBEEF,'h0000100, 32'h08000100, 1);
    vt[22] = mk(22, 31, 31, 31, 31,'hBEEF,'h3FFFFFF, 32'h0FFFFFFF, 1);

    clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ld = 1'b0; ld_addr = '0;
    mnem = '0; rs = '0; rt = '0; rd = '0; sa = '0; imm = '0; target = '0;
    #12;
    check_reset_outputs("reset");
    clrn = 1'b1;
    tick();

    // Table: every mnemonic, one at a time, with the address counter running.
    exp_addr = '0;
    for (int i = 0; i < 23; i++) begin
      send(vt[i].mnem, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].sa, vt[i].imm, vt[i].target);
      chk($sformatf("v%0d_level", i), 32'(level), 32'd1);
`ifdef ENCODER_DELAY_SLOT_EN
      if (vt[i].br) chk($sformatf("v%0d_ready_low", i), 32'(in_ready), 32'd0);
`endif
      expect_head($sformatf("v%0d", i), vt[i].exp, exp_addr);
      exp_addr++;
`ifdef ENCODER_DELAY_SLOT_EN
      if (vt[i].br) begin
        chk($sformatf("v%0d_ready_back", i), 32'(in_ready), 32'd1);
        expect_head($sformatf("v%0d_nop", i), 32'h0, exp_addr);
        exp_addr++;
      end
`endif
      chk($sformatf("v%0d_drained", i), 32'(level), 32'd0);
    end

    // Push and pop on the same edge while not full: level holds.
    send_add(1);
    rd = 5'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pushpop_level", 32'(level), 32'd1);
    exp_addr++;
    expect_head("pushpop", 32'h00001020, exp_addr);
    exp_addr++;

    // ld alone, then ld together with a push, wrapping the counter.
    ld = 1'b1; ld_addr = 8'h40;
    tick();
    ld = 1'b0;
    send_add(3);
    expect_head("ld_only", 32'h00001820, 8'h40);
    ld = 1'b1; ld_addr = 8'hFF;
    send(5'd21, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0000100);
    send(5'd22, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0000040);
`ifdef ENCODER_DELAY_SLOT_EN
    tick();
    expect_head("ld_j", 32'h08000100, 8'hFF);
    expect_head("ld_j_nop", 32'h0, 8'h00);
    expect_head("wrap_jal", 32'h0C000040, 8'h01);
    expect_head("wrap_jal_nop", 32'h0, 8'h02);
`else
    expect_head("ld_j", 32'h08000100, 8'hFF);
    expect_head("wrap_jal", 32'h0C000040, 8'h00);
`endif

    // Fill the FIFO with out_ready low, then drain in order.
    clrn = 1'b0;
    #2;
    clrn = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      send_add(k + 1);
      chk($sformatf("fill%0d_ready", k), 32'(in_ready), (k < 3) ? 32'd1 : 32'd0);
    end
    chk("full_level", 32'(level), 32'd4);
    rd = 5'd5; in_valid = 1'b1;
    tick();
    chk("full_blocked_level", 32'(level), 32'd4);
    chk("full_head", out_inst, 32'h00000820);
    out_ready = 1'b1;
    tick();
    chk("full_pop_nopush_level", 32'(level), 32'd3);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("refill_level", 32'(level), 32'd4);
    expect_head("drain1", 32'h00001020, 8'd1);
    expect_head("drain2", 32'h00001820, 8'd2);
    expect_head("drain3", 32'h00002020, 8'd3);
    expect_head("drain4", 32'h00002820, 8'd4);
    chk("drained_level", 32'(level), 32'd0);

    // 300 illegal commands: no pushes, one err pulse each, saturating count.
    pulses = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      mnem = (i == 0) ? 5'd23 : (i == 1) ? 5'd31 : 5'd25;
      tick();
      if (err) pulses++;
      if (i == 9) chk("err_cnt_10", 32'(err_cnt), 32'd10);
    end
    in_valid = 1'b0;
    chk("err_pulses", pulses, 32'd300);
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
    chk("illegal_level", 32'(level), 32'd0);
    tick();
    chk("err_clear", 32'(err), 32'd0);
    send_add(1);
    chk("illegal_no_advance_addr", 32'(out_addr), 32'd5);

    // Asynchronous reset in the middle of a stream.
    send_add(2);
    chk("pre_reset_level", 32'(level), 32'd2);
    mnem = 5'd0; rd = 5'd3; in_valid = 1'b1;
    #2;
    clrn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    in_valid = 1'b0;
    #2;
    clrn = 1'b1;
    tick();
    send_add(7);
    expect_head("post_reset", 32'h00003820, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
